// File: rtl/nextasic_pkg.sv
// Shared monitor-link definitions: frame width common to the transmit and receive paths,
// and the transmitter FSM state encoding.
package nextasic_pkg;
  localparam int MON_FRAME_W = 40;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    GAP
  } tx_state_t;
endpackage

// File: rtl/mon_transmitter_if.sv
// Word handshake into the monitor-link transmitter (valid/ready, one word per transfer).
interface mon_transmitter_if
  import nextasic_pkg::*;
#(
  parameter int FRAME_W = MON_FRAME_W
);
  logic [FRAME_W-1:0] data;
  logic               data_valid;
  logic               data_ready;

  modport master (output data, output data_valid, input data_ready);
  modport slave  (input data, input data_valid, output data_ready);
endinterface

// File: rtl/mon_transmitter.sv
// Monitor-link serial transmitter: one-word holding register, shifter and frame FSM on mon_clk.
// Define NEXTASIC_TX_PARITY_EN to append an even-parity bit after the data bits.
module mon_transmitter
  import nextasic_pkg::*;
#(
  parameter int FRAME_W    = MON_FRAME_W,
  parameter int GAP_CYCLES = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic              mon_clk,
  input  logic              reset,
  mon_transmitter_if.slave  tx,
  output logic              from_mon,
  output logic              busy,
  output logic              frame_sent
);

  localparam int               CNT_W    = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] BIT_PEN  = CNT_W'(FRAME_W - 2);
  localparam logic [7:0]       GAP_LAST = 8'(GAP_CYCLES - 1);

  tx_state_t          r_state;
  logic [FRAME_W-1:0] r_hold;
  logic               r_hold_valid;
  logic [FRAME_W-1:0] r_shift;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [7:0]         r_gap_cnt;
  logic               r_from_mon;
  logic               r_frame_sent;
`ifdef NEXTASIC_TX_PARITY_EN
  logic               r_parity;
`endif

  tx_state_t          w_state_nxt;
  logic               w_accept;
  logic               w_load;
  logic               w_shift;
  logic               w_from_mon_nxt;
  logic               w_frame_sent_nxt;
  logic [CNT_W-1:0]   w_bit_cnt_nxt;
  logic [7:0]         w_gap_cnt_nxt;
  logic               w_head;
  logic [FRAME_W-1:0] w_shifted;

  assign tx.data_ready = ~r_hold_valid & ~reset;
  assign w_accept      = tx.data_valid & tx.data_ready;
  assign w_head        = MSB_FIRST ? r_shift[FRAME_W-1] : r_shift[0];
  assign w_shifted     = MSB_FIRST ? {r_shift[FRAME_W-2:0], 1'b0} : {1'b0, r_shift[FRAME_W-1:1]};

  assign from_mon   = r_from_mon;
  assign busy       = ((r_state != IDLE) | r_hold_valid) & ~reset;
  assign frame_sent = r_frame_sent & ~reset;

  // Next-state logic: the registered line value always reflects the state being entered.
  always_comb begin
    w_state_nxt      = r_state;
    w_load           = 1'b0;
    w_shift          = 1'b0;
    w_from_mon_nxt   = 1'b0;
    w_frame_sent_nxt = 1'b0;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_gap_cnt_nxt    = r_gap_cnt;
    case (r_state)
      IDLE: begin
        if (r_hold_valid) begin
          w_state_nxt    = START;
          w_load         = 1'b1;
          w_from_mon_nxt = 1'b1;
        end
      end
      START: begin
        w_state_nxt    = DATA;
        w_from_mon_nxt = w_head;
        w_shift        = 1'b1;
        w_bit_cnt_nxt  = '0;
      end
      DATA: begin
        if (r_bit_cnt == BIT_LAST) begin
`ifdef NEXTASIC_TX_PARITY_EN
          w_state_nxt      = PARITY;
          w_from_mon_nxt   = r_parity;
          w_frame_sent_nxt = 1'b1;
`else
          w_state_nxt      = GAP;
          w_gap_cnt_nxt    = '0;
`endif
        end else begin
          w_from_mon_nxt = w_head;
          w_shift        = 1'b1;
          w_bit_cnt_nxt  = r_bit_cnt + 1'b1;
`ifndef NEXTASIC_TX_PARITY_EN
          w_frame_sent_nxt = (r_bit_cnt == BIT_PEN);
`endif
        end
      end
`ifdef NEXTASIC_TX_PARITY_EN
      PARITY: begin
        w_state_nxt   = GAP;
        w_gap_cnt_nxt = '0;
      end
`endif
      GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          // A word already waiting in the holding register starts with no idle cycle.
          if (r_hold_valid) begin
            w_state_nxt    = START;
            w_load         = 1'b1;
            w_from_mon_nxt = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mon_clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_from_mon   <= 1'b0;
      r_frame_sent <= 1'b0;
`ifdef NEXTASIC_TX_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_from_mon   <= w_from_mon_nxt;
      r_frame_sent <= w_frame_sent_nxt;
      if (w_accept) begin
        r_hold       <= tx.data;
        r_hold_valid <= 1'b1;
      end else if (w_load) begin
        r_hold_valid <= 1'b0;
      end
      if (w_load) begin
        r_shift  <= r_hold;
`ifdef NEXTASIC_TX_PARITY_EN
        r_parity <= ^r_hold;
`endif
      end else if (w_shift) begin
        r_shift <= w_shifted;
      end
    end
  end

endmodule
